// File: rtl/hit_log_pkg.sv
// Shared types and log-word layout for the hit log arbiter.
package hit_log_pkg;

  localparam int unsigned NUM_SRC = 4;

  typedef enum logic [1:0] {
    SRC_PORT = 2'd0,
    SRC_IP   = 2'd1,
    SRC_MAC  = 2'd2,
    SRC_URL  = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    WRITE_TS = 2'd2
  } state_e;

  // Id word: {onehot source[31:28], zero[27:16], tag[15:0]}
  localparam int unsigned LOG_SRC_LSB = 28;
  localparam int unsigned LOG_SRC_W   = 4;
  localparam int unsigned LOG_TAG_LSB = 0;
  localparam int unsigned LOG_TAG_W   = 16;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [1:0] idx);
    logic [NUM_SRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [31:0] id_word(input logic [1:0]           src,
                                          input logic [LOG_TAG_W-1:0] tag);
    logic [31:0] w;
    w                              = '0;
    w[LOG_SRC_LSB +: LOG_SRC_W]    = onehot(src);
    w[LOG_TAG_LSB +: LOG_TAG_W]    = tag;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin grant; search starts one past the last winner.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] rr_last_i,
  output logic       gnt_valid_o,
  output logic [1:0] gnt_idx_o
);

  logic [1:0] cand;

  // Walk from lowest to highest priority so the highest-priority request is assigned last.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = 2'd0;
    cand        = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      cand = rr_last_i + 2'(i);
      if (req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hit_log_arbiter.sv
// Round-robin arbiter that logs comparator hits into a circular memory region and counts them.
// Define HIT_TIMESTAMP_EN to append a 32-bit cycle timestamp word to every log entry.
module hit_log_arbiter
  import hit_log_pkg::*;
#(
  parameter logic [31:0] LOG_BASE  = 32'h0000_1000,
  parameter int unsigned LOG_DEPTH = 256,
  parameter int unsigned PKT_ID_W  = 16
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic [NUM_SRC-1:0]           hit_req,
  input  logic [NUM_SRC*PKT_ID_W-1:0]  hit_pkt_id,
  output logic [NUM_SRC-1:0]           hit_ack,
  input  logic                         log_enable,
  input  logic                         clear_counts,
  input  logic                         write_wait,
  output logic [31:0]                  addr_out,
  output logic                         write_enable,
  output logic [31:0]                  data_out,
  output logic [63:0]                  port_hits,
  output logic [63:0]                  ip_hits,
  output logic [63:0]                  mac_hits,
  output logic [63:0]                  url_hits,
  output logic                         log_wrapped
);

  localparam int unsigned PTR_W = $clog2(LOG_DEPTH);
`ifdef HIT_TIMESTAMP_EN
  localparam int unsigned ENTRY_SHIFT = 3;
`else
  localparam int unsigned ENTRY_SHIFT = 2;
`endif

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         rr_last_q, rr_last_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic               wrapped_q, wrapped_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        data_q, data_d;
  logic               we_q, we_d;
  logic [63:0]        cnt_q [NUM_SRC];
  logic [63:0]        cnt_d [NUM_SRC];
`ifdef HIT_TIMESTAMP_EN
  logic [31:0]        ts_q, ts_d;
  logic [31:0]        ts_lat_q, ts_lat_d;
`endif

  logic               gnt_valid;
  logic [1:0]         gnt_idx;
  logic               fire;
  logic               complete;
  logic [1:0]         ack_idx;
  logic [PKT_ID_W-1:0] tag_sel;
  logic [LOG_TAG_W-1:0] tag16;
  logic [31:0]        entry_addr;

  rr_arbiter4 u_rr_arbiter4 (
    .req_i       (hit_req),
    .rr_last_i   (rr_last_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign tag_sel    = hit_pkt_id[int'(gnt_idx) * PKT_ID_W +: PKT_ID_W];
  assign entry_addr = LOG_BASE + (32'(wr_ptr_q) << ENTRY_SHIFT);

  if (PKT_ID_W >= LOG_TAG_W) begin : g_tag_trunc
    assign tag16 = tag_sel[LOG_TAG_W-1:0];
  end else begin : g_tag_ext
    assign tag16 = {{(LOG_TAG_W-PKT_ID_W){1'b0}}, tag_sel};
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    wr_ptr_d  = wr_ptr_q;
    wrapped_d = wrapped_q;
    addr_d    = addr_q;
    data_d    = data_q;
    we_d      = we_q;
    complete  = 1'b0;
    fire      = 1'b0;
    ack_idx   = grant_q;
`ifdef HIT_TIMESTAMP_EN
    ts_d      = ts_q + 32'd1;
    ts_lat_d  = ts_lat_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          if (log_enable) begin
            state_d = WRITE;
            grant_d = gnt_idx;
            we_d    = 1'b1;
            addr_d  = entry_addr;
            data_d  = id_word(gnt_idx, tag16);
`ifdef HIT_TIMESTAMP_EN
            ts_lat_d = ts_q;
`endif
          end else begin
            // Count-only mode: acknowledge immediately without touching memory.
            fire    = 1'b1;
            ack_idx = gnt_idx;
          end
        end
      end
      WRITE: begin
        if (!write_wait) begin
`ifdef HIT_TIMESTAMP_EN
          state_d = WRITE_TS;
          addr_d  = addr_q + 32'd4;
          data_d  = ts_lat_q;
`else
          complete = 1'b1;
`endif
        end
      end
      WRITE_TS: begin
`ifdef HIT_TIMESTAMP_EN
        if (!write_wait) complete = 1'b1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      fire     = 1'b1;
      state_d  = IDLE;
      we_d     = 1'b0;
      addr_d   = '0;
      data_d   = '0;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == PTR_W'(LOG_DEPTH - 1)) wrapped_d = 1'b1;
    end

    if (fire) rr_last_d = ack_idx;

    for (int i = 0; i < NUM_SRC; i++) begin
      if (clear_counts) begin
        cnt_d[i] = '0;
      end else if (fire && (ack_idx == 2'(i))) begin
        cnt_d[i] = cnt_q[i] + 64'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'd0;
      rr_last_q <= 2'd3;
      wr_ptr_q  <= '0;
      wrapped_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '{default: '0};
`ifdef HIT_TIMESTAMP_EN
      ts_q      <= '0;
      ts_lat_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      wr_ptr_q  <= wr_ptr_d;
      wrapped_q <= wrapped_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
`ifdef HIT_TIMESTAMP_EN
      ts_q      <= ts_d;
      ts_lat_q  <= ts_lat_d;
`endif
    end
  end

  // Ack is suppressed while reset is asserted so an abandoned write is never acknowledged.
  assign hit_ack      = (fire && n_rst) ? onehot(ack_idx) : '0;
  assign addr_out     = addr_q;
  assign data_out     = data_q;
  assign write_enable = we_q;
  assign log_wrapped  = wrapped_q;
  assign port_hits    = cnt_q[SRC_PORT];
  assign ip_hits      = cnt_q[SRC_IP];
  assign mac_hits     = cnt_q[SRC_MAC];
  assign url_hits     = cnt_q[SRC_URL];

endmodule

// File: tb/tb_hit_log_arbiter.sv
// Scoreboard bench for hit_log_arbiter: stimulus queues expected writes/acks, a monitor checks them.
module tb_hit_log_arbiter;

  logic        clk;
  logic        n_rst;
  logic [3:0]  hit_req;
  logic [63:0] hit_pkt_id;
  logic [3:0]  hit_ack;
  logic        log_enable;
  logic        clear_counts;
  logic        write_wait;
  logic [31:0] addr_out;
  logic        write_enable;
  logic [31:0] data_out;
  logic [63:0] port_hits, ip_hits, mac_hits, url_hits;
  logic        log_wrapped;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_wr[$];   // {addr, data}
  logic [3:0]  exp_ack[$];
  logic [3:0]  ack_last;

  hit_log_arbiter dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .hit_req      (hit_req),
    .hit_pkt_id   (hit_pkt_id),
    .hit_ack      (hit_ack),
    .log_enable   (log_enable),
    .clear_counts (clear_counts),
    .write_wait   (write_wait),
    .addr_out     (addr_out),
    .write_enable (write_enable),
    .data_out     (data_out),
    .port_hits    (port_hits),
    .ip_hits      (ip_hits),
    .mac_hits     (mac_hits),
    .url_hits     (url_hits),
    .log_wrapped  (log_wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [63:0] w;
    forever begin
      @(negedge clk);
      ack_last = hit_ack;
      if (n_rst) begin
        if (write_enable && !write_wait) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write",
                     addr_out, data_out);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 64'(addr_out), 64'(w[63:32]));
            chk("wr_data", 64'(data_out), 64'(w[31:0]));
          end
        end
        if (hit_ack != 4'b0) begin
          if (exp_ack.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got %b expected none", hit_ack);
          end else begin
            chk("ack", 64'(hit_ack), 64'(exp_ack.pop_front()));
          end
        end
      end
    end
  endtask

  // Advance one clock; requests whose ack was seen this cycle are withdrawn.
  task automatic tick();
    @(posedge clk);
    #1;
    hit_req = hit_req & ~ack_last;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (hit_req != 4'b0 && n < 50) begin
      tick();
      n++;
    end
    if (hit_req != 4'b0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got req %b expected 0000", hit_req);
      hit_req = 4'b0;
    end
  endtask

  task automatic do_reset();
    n_rst   = 1'b0;
    hit_req = 4'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic expect_hit(input int src, input logic [15:0] tag, input logic [31:0] addr);
    logic [3:0] oh;
    oh = 4'b0001 << src;
    hit_pkt_id[src*16 +: 16] = tag;
    exp_wr.push_back({addr, oh, 12'h000, tag});
    exp_ack.push_back(oh);
  endtask

  task automatic hit(input int src, input logic [15:0] tag, input logic [31:0] addr);
    expect_hit(src, tag, addr);
    hit_req[src] = 1'b1;
    wait_drain();
  endtask

  initial begin
    n_rst        = 1'b0;
    hit_req      = 4'hF;
    hit_pkt_id   = '0;
    log_enable   = 1'b1;
    clear_counts = 1'b0;
    write_wait   = 1'b0;
    ack_last     = 4'b0;
    fork
      monitor();
    join_none

    // Reset with all requests high.
    for (int c = 0; c < 2; c++) begin
      tick();
      @(negedge clk);
      chk("rst_ack", 64'(hit_ack), 64'h0);
      chk("rst_we", 64'(write_enable), 64'h0);
      chk("rst_addr", 64'(addr_out), 64'h0);
    end
    chk("rst_port", port_hits, 64'h0);
    chk("rst_ip", ip_hits, 64'h0);
    chk("rst_mac", mac_hits, 64'h0);
    chk("rst_url", url_hits, 64'h0);
    chk("rst_wrap", 64'(log_wrapped), 64'h0);
    hit_req = 4'b0;
    n_rst   = 1'b1;
    tick();

    // Single ip hit.
    hit(1, 16'h0042, 32'h0000_1000);
    chk("single_ip_hits", ip_hits, 64'd1);
    chk("single_port_hits", port_hits, 64'd0);

    // Contention: all four held, round-robin from source 0.
    do_reset();
    expect_hit(0, 16'hA000, 32'h0000_1000);
    expect_hit(1, 16'hB001, 32'h0000_1004);
    expect_hit(2, 16'hC002, 32'h0000_1008);
    expect_hit(3, 16'hD003, 32'h0000_100C);
    hit_req = 4'hF;
    wait_drain();
    chk("cont_port", port_hits, 64'd1);
    chk("cont_ip", ip_hits, 64'd1);
    chk("cont_mac", mac_hits, 64'd1);
    chk("cont_url", url_hits, 64'd1);

    // Backpressure: three wait cycles in WRITE, ack only on the fourth.
    expect_hit(2, 16'hC0DE, 32'h0000_1010);
    write_wait = 1'b1;
    hit_req    = 4'b0100;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_we", 64'(write_enable), 64'h1);
      chk("bp_addr", 64'(addr_out), 64'h1010);
      chk("bp_data", 64'(data_out), 64'h4000_C0DE);
      chk("bp_noack", 64'(hit_ack), 64'h0);
      tick();
    end
    write_wait = 1'b0;
    @(negedge clk);
    chk("bp_we4", 64'(write_enable), 64'h1);
    chk("bp_ack4", 64'(hit_ack), 64'b0100);
    wait_drain();
    chk("bp_mac", mac_hits, 64'd2);

    // Wrap: 256 url hits fill the log, the 257th lands at entry 0 again.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      hit(3, 16'(i), 32'h0000_1000 + 32'(4 * i));
      if (i == 254) chk("wrap_not_yet", 64'(log_wrapped), 64'h0);
    end
    chk("wrap_set", 64'(log_wrapped), 64'h1);
    chk("wrap_url256", url_hits, 64'd256);
    hit(3, 16'h0BEE, 32'h0000_1000);
    chk("wrap_url257", url_hits, 64'd257);

    // Clear coincident with an ack wins over the increment.
    expect_hit(3, 16'h0CAB, 32'h0000_1004);
    hit_req = 4'b1000;
    tick();
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("clear_url", url_hits, 64'd0);
    chk("clear_keeps_wrap", 64'(log_wrapped), 64'h1);

    // Count-only mode: same-cycle ack, no memory write.
    log_enable = 1'b0;
    exp_ack.push_back(4'b0001);
    hit_req = 4'b0001;
    @(negedge clk);
    chk("cnt_only_ack", 64'(hit_ack), 64'b0001);
    chk("cnt_only_we", 64'(write_enable), 64'h0);
    wait_drain();
    chk("cnt_only_port", port_hits, 64'd1);
    @(negedge clk);
    chk("cnt_only_we_after", 64'(write_enable), 64'h0);
    log_enable = 1'b1;

    repeat (3) tick();
    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("ack_queue_empty", 64'(exp_ack.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
